wb_bram_ctrl: RTL and testbench
===============================

# wb_bram_ctrl

Wishbone slave that owns the single port of a user-area block RAM (byte-enabled, one registered read cycle, 2^N 32-bit words) and turns Caravel Wishbone classic cycles into RAM accesses. A programmable countdown inserts DELAYS wait cycles before each access to model slow external memory. `wbs_ack_o` is raised exactly once per accepted cycle. Sits between the user-project Wishbone port and the RAM instance in the user project wrapper.

## Interface
- DELAYS, 10: wait cycles inserted between request acceptance and RAM access (0 allowed)
- N, 9: RAM word-address width (RAM depth 2^N words)
- BASE, 8'h38: value of wbs_adr_i[31:24] that selects this block
- wb_clk_i  in  1  single clock; everything is on its rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write, 0 = read
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data, valid only while wbs_ack_o = 1
- wbs_ack_o  out  1  one-cycle acknowledge
- bram_en  out  1  RAM enable
- bram_we  out  4  RAM byte write enables
- bram_a  out  32  RAM word address = {{(32-N){0}}, adr[N+1:2]}
- bram_di  out  32  RAM write data
- bram_do  in  32  RAM read data, registered by the RAM; forced to 0 by the RAM when bram_en = 0

## Operation
- hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE). Non-hits are ignored; the block does not ack them.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: on hit, latch we, sel, word address, dat_i; load cnt = DELAYS; go to WAIT if DELAYS > 0, else go to ACCESS.
- WAIT: cnt decrements each cycle; go to ACCESS when cnt reaches 1 → 0. If wbs_cyc_i or wbs_stb_i drops, abort to IDLE, with no RAM access and no ack.
- ACCESS: bram_en = 1, bram_a/bram_di from the latches, bram_we = we ? sel : 4'b0. Unconditional next state RESP. No abort is possible once in ACCESS.
- RESP: wbs_ack_o = 1. wbs_dat_o = bram_do for reads, 32'h0 for writes. Then IDLE.
- bram_en = 0 and bram_we = 0 in every state except ACCESS. bram_a and bram_di hold their latched values.
- Write bytes with sel bit clear are left untouched in the RAM. Reads ignore sel and return the full word.
- cnt width is $clog2(DELAYS+1), minimum 1.

## Timing
- Hit sampled in IDLE at cycle t. WAIT occupies t+1 … t+DELAYS, ACCESS is t+DELAYS+1, ack is at t+DELAYS+2. With the defaults, ack arrives 12 cycles after the request.
- Ack is high for exactly one cycle. The master drops stb after ack, so the earliest next acceptance is at t+DELAYS+3. Back-to-back transfers have a throughput of one per DELAYS+3 cycles.
- Write followed by a read of the same address returns the new data. The write completes in its ACCESS cycle, before any later read's ACCESS.
- Reset values: wbs_ack_o = 0, wbs_dat_o = 0, bram_en = 0, bram_we = 0, bram_a = 0, bram_di = 0, cnt = 0, state = IDLE.
- wb_rst_i asserted in any state: IDLE on the next edge. If reset lands in ACCESS, that write may land in the RAM, but no ack is issued.
- A hit arriving in WAIT/ACCESS/RESP for a different address is not queued. It is seen again in IDLE because the master holds stb.

## Structure
- Shared package wb_bram_pkg holds the state enum (IDLE, WAIT, ACCESS, RESP), the default BASE constant, and the localparam for the word-address slice.
- One natural sub-module: delay_counter (load, decrement, zero flag, parameter DELAYS). Everything else stays flat in wb_bram_ctrl.
- The RAM itself is instantiated outside, by the wrapper.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles with stb low. bram_en never pulses.
- Write 0x3800_0010 data 0xDEADBEEF sel 4'hF, then read the same address. Write ack at t+12 with bram_we = 4'hF, bram_a = 4 during ACCESS. Read returns 0xDEADBEEF at its ack.
- Partial write sel 4'b0100 data 0x00AA_0000 over 0x11223344, then read. The read returns 0x11AA3344.
- Stb dropped at t+5 during WAIT: no bram_en pulse, no ack, FSM back in IDLE at t+6.
- Address 0x3000_0000 with stb held for 30 cycles: no ack and no bram_en. Parameter sweep DELAYS = 0: ack at t+2.
- wb_rst_i pulsed at t+3 of a read: all outputs 0 at t+4 and no ack. A new read at t+6 acks at t+18 with correct data.

Source files
------------

// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the Wishbone-to-BRAM controller.
package wb_bram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

  // Default value of wbs_adr_i[31:24] that selects this block
  localparam logic [7:0] BASE_DEFAULT = 8'h38;

  // Word-address slice of the byte address starts at bit 2 (32-bit words)
  localparam int unsigned ADR_LSB = 2;

  // Countdown width: enough bits to hold DELAYS, never less than one
  function automatic int unsigned cnt_width(input int unsigned delays);
    int unsigned w;
    w = $clog2(delays + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Byte write enables presented to the RAM for a latched request
  function automatic logic [3:0] lane_we(input logic we, input logic [3:0] sel);
    return we ? sel : 4'b0000;
  endfunction

endpackage

// File: rtl/wb_bram_ctrl_if.sv
// Wishbone classic slave-side signal bundle (Caravel user-project port).
interface wb_bram_ctrl_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );

endinterface

// File: rtl/wb_bram_ctrl_delay_counter.sv
// Loadable down-counter that paces the wait cycles before each RAM access.
module delay_counter
  import wb_bram_pkg::*;
#(
  parameter int unsigned DELAYS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero,
  output logic last
);

  localparam int unsigned CW = cnt_width(DELAYS);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(DELAYS);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave owning the single port of a byte-enabled, registered-read
// block RAM, with a programmable number of wait cycles before each access.
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter int unsigned DELAYS = 10,
  parameter int unsigned N      = 9,
  parameter logic [7:0]  BASE   = BASE_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_bram_ctrl_if.slave      wbs,
  output logic               bram_en,
  output logic [3:0]         bram_we,
  output logic [31:0]        bram_a,
  output logic [31:0]        bram_di,
  input  logic [31:0]        bram_do
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] bram_a_q, bram_a_d;
  logic [31:0] bram_di_q, bram_di_d;
  logic        bram_en_q, bram_en_d;
  logic [3:0]  bram_we_q, bram_we_d;
  logic        ack_q, ack_d;

  logic        hit;
  logic        cnt_load, cnt_dec, cnt_zero, cnt_last;

  // Low byte-address bits and bits above the RAM depth do not reach the RAM
  logic        unused_adr_bits;
  assign unused_adr_bits = ^wbs.wbs_adr_i[23:0];

  assign hit = wbs.wbs_cyc_i && wbs.wbs_stb_i && (wbs.wbs_adr_i[31:24] == BASE);

  delay_counter #(
    .DELAYS (DELAYS)
  ) u_delay_counter (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero),
    .last (cnt_last)
  );

  // Next-state logic; RAM strobes and ack are computed one cycle ahead so
  // that they come straight from flops in the state they belong to
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    bram_a_d  = bram_a_q;
    bram_di_d = bram_di_q;
    bram_en_d = 1'b0;
    bram_we_d = 4'b0000;
    ack_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          we_d      = wbs.wbs_we_i;
          sel_d     = wbs.wbs_sel_i;
          bram_a_d  = 32'(wbs.wbs_adr_i[N+1:ADR_LSB]);
          bram_di_d = wbs.wbs_dat_i;
          cnt_load  = 1'b1;
          if (DELAYS == 0) begin
            state_d   = ACCESS;
            bram_en_d = 1'b1;
            bram_we_d = lane_we(wbs.wbs_we_i, wbs.wbs_sel_i);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!(wbs.wbs_cyc_i && wbs.wbs_stb_i)) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_last || cnt_zero) begin
            state_d   = ACCESS;
            bram_en_d = 1'b1;
            bram_we_d = lane_we(we_q, sel_q);
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack_d   = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      sel_q     <= 4'b0000;
      bram_a_q  <= '0;
      bram_di_q <= '0;
      bram_en_q <= 1'b0;
      bram_we_q <= 4'b0000;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      bram_a_q  <= bram_a_d;
      bram_di_q <= bram_di_d;
      bram_en_q <= bram_en_d;
      bram_we_q <= bram_we_d;
      ack_q     <= ack_d;
    end
  end

  assign bram_en  = bram_en_q;
  assign bram_we  = bram_we_q;
  assign bram_a   = bram_a_q;
  assign bram_di  = bram_di_q;
  assign wbs.wbs_ack_o = ack_q;
  // Read data only becomes valid after the ACCESS edge, so it is steered
  // combinationally from the RAM output during RESP
  assign wbs.wbs_dat_o = (ack_q && !we_q) ? bram_do : '0;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: one instance with the default 10 wait
// cycles and one with none, each with its own behavioural RAM.
module tb_wb_bram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, use1 = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;

  wb_bram_ctrl_if wb0 ();
  wb_bram_ctrl_if wb1 ();

  assign wb0.wbs_cyc_i = cyc & ~use1;
  assign wb0.wbs_stb_i = stb & ~use1;
  assign wb0.wbs_we_i  = we;
  assign wb0.wbs_sel_i = sel;
  assign wb0.wbs_adr_i = adr;
  assign wb0.wbs_dat_i = dat;
  assign wb1.wbs_cyc_i = cyc & use1;
  assign wb1.wbs_stb_i = stb & use1;
  assign wb1.wbs_we_i  = we;
  assign wb1.wbs_sel_i = sel;
  assign wb1.wbs_adr_i = adr;
  assign wb1.wbs_dat_i = dat;

  logic        en0, en1;
  logic [3:0]  bwe0, bwe1;
  logic [31:0] ba0, ba1, bdi0, bdi1;
  logic [31:0] bdo0 = '0, bdo1 = '0;

  wb_bram_ctrl #(.DELAYS(10), .N(9), .BASE(8'h38)) dut0 (
    .wb_clk_i (clk), .wb_rst_i (rst), .wbs (wb0.slave),
    .bram_en (en0), .bram_we (bwe0), .bram_a (ba0), .bram_di (bdi0), .bram_do (bdo0)
  );

  wb_bram_ctrl #(.DELAYS(0), .N(9), .BASE(8'h38)) dut1 (
    .wb_clk_i (clk), .wb_rst_i (rst), .wbs (wb1.slave),
    .bram_en (en1), .bram_we (bwe1), .bram_a (ba1), .bram_di (bdi1), .bram_do (bdo1)
  );

  // Behavioural RAMs: byte-enabled write, registered read, output 0 when idle
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (en0) begin
      mem0[ba0[8:0]] <= merge(mem0[ba0[8:0]], bdi0, bwe0);
      bdo0 <= mem0[ba0[8:0]];
    end else begin
      bdo0 <= '0;
    end
  end

  always @(posedge clk) begin
    if (en1) begin
      mem1[ba1[8:0]] <= merge(mem1[ba1[8:0]], bdi1, bwe1);
      bdo1 <= mem1[ba1[8:0]];
    end else begin
      bdo1 <= '0;
    end
  end

  logic        cur_en, cur_ack;
  logic [3:0]  cur_bwe;
  logic [31:0] cur_a, cur_di, cur_dat;
  assign cur_en  = use1 ? en1 : en0;
  assign cur_ack = use1 ? wb1.wbs_ack_o : wb0.wbs_ack_o;
  assign cur_bwe = use1 ? bwe1 : bwe0;
  assign cur_a   = use1 ? ba1 : ba0;
  assign cur_di  = use1 ? bdi1 : bdi0;
  assign cur_dat = use1 ? wb1.wbs_dat_o : wb0.wbs_dat_o;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone cycle; returns ticks from request to ack and what the RAM saw
  task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [31:0] rd,
                      output logic [3:0] obwe, output logic [31:0] oba,
                      output logic [31:0] obdi, output int pulses);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    lat = 0; rd = '0; obwe = '0; oba = '0; obdi = '0; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cur_en) begin
        pulses++;
        obwe = cur_bwe;
        oba  = cur_a;
        obdi = cur_di;
      end
      if (cur_ack) begin
        lat = i;
        rd  = cur_dat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
  endtask

  typedef struct {
    logic        d1;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp_rd;
    logic [3:0]  exp_bwe;
    logic [31:0] exp_a;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int          lat, pulses, acks;
    logic [31:0] rd, ba, bdi;
    logic [3:0]  bwe;

    vecs[0]  = '{1'b0, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 32'h0,         4'hF, 32'd4};
    vecs[1]  = '{1'b0, 1'b0, 4'hF, 32'h3800_0010, 32'h0,         32'hDEAD_BEEF, 4'h0, 32'd4};
    vecs[2]  = '{1'b0, 1'b1, 4'hF, 32'h3800_0020, 32'h1122_3344, 32'h0,         4'hF, 32'd8};
    vecs[3]  = '{1'b0, 1'b1, 4'h4, 32'h3800_0020, 32'h00AA_0000, 32'h0,         4'h4, 32'd8};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 32'h3800_0020, 32'h0,         32'h11AA_3344, 4'h0, 32'd8};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 32'h3800_0010, 32'h5555_5555, 32'hDEAD_BEEF, 4'h0, 32'd4};
    vecs[6]  = '{1'b0, 1'b1, 4'hF, 32'h3800_07FC, 32'hFFFF_FFFF, 32'h0,         4'hF, 32'd511};
    vecs[7]  = '{1'b0, 1'b1, 4'h3, 32'h3800_07FC, 32'hCAFE_F00D, 32'h0,         4'h3, 32'd511};
    vecs[8]  = '{1'b0, 1'b0, 4'hF, 32'h3800_07FC, 32'h0,         32'hFFFF_F00D, 4'h0, 32'd511};
    vecs[9]  = '{1'b0, 1'b0, 4'hF, 32'h3800_0810, 32'h0,         32'hDEAD_BEEF, 4'h0, 32'd4};
    vecs[10] = '{1'b1, 1'b1, 4'hF, 32'h3800_0004, 32'hA5A5_A5A5, 32'h0,         4'hF, 32'd1};
    vecs[11] = '{1'b1, 1'b0, 4'hF, 32'h3800_0004, 32'h0,         32'hA5A5_A5A5, 4'h0, 32'd1};
    vecs[12] = '{1'b1, 1'b1, 4'h2, 32'h3800_0004, 32'h0000_3C00, 32'h0,         4'h2, 32'd1};
    vecs[13] = '{1'b1, 1'b0, 4'hF, 32'h3800_0004, 32'h0,         32'hA5A5_3CA5, 4'h0, 32'd1};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_ctl0",  {29'd0, wb0.wbs_ack_o, en0, |bwe0}, 32'h0);
    check("rst_data0", ba0 | bdi0 | wb0.wbs_dat_o, 32'h0);
    check("rst_ctl1",  {29'd0, wb1.wbs_ack_o, en1, |bwe1}, 32'h0);
    check("rst_data1", ba1 | bdi1 | wb1.wbs_dat_o, 32'h0);
    rst = 1'b0;

    // Idle with strobe low
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ctl",  {26'd0, wb0.wbs_ack_o, en0, |bwe0, wb1.wbs_ack_o, en1, |bwe1}, 32'h0);
      check("idle_data", ba0 | bdi0 | wb0.wbs_dat_o | ba1 | bdi1 | wb1.wbs_dat_o, 32'h0);
    end

    // Vector table
    for (int v = 0; v < 14; v++) begin
      use1 = vecs[v].d1;
      xfer(vecs[v].we, vecs[v].sel, vecs[v].adr, vecs[v].dat, lat, rd, bwe, ba, bdi, pulses);
      check($sformatf("v%0d_latency", v), 32'(lat), vecs[v].d1 ? 32'd2 : 32'd12);
      check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      check($sformatf("v%0d_bram_we", v), {28'd0, bwe}, {28'd0, vecs[v].exp_bwe});
      check($sformatf("v%0d_bram_a", v), ba, vecs[v].exp_a);
      check($sformatf("v%0d_bram_di", v), bdi, vecs[v].dat);
      check($sformatf("v%0d_en_pulses", v), 32'(pulses), 32'd1);
      check($sformatf("v%0d_ack_single", v), {31'd0, cur_ack}, 32'h0);
    end
    use1 = 1'b0;

    // Strobe dropped during WAIT: aborted write must not reach the RAM
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3800_0010; dat = 32'h1234_5678;
    pulses = 0; acks = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      pulses += int'(en0);
      acks   += int'(wb0.wbs_ack_o);
    end
    stb = 1'b0;
    tick();
    pulses += int'(en0);
    acks   += int'(wb0.wbs_ack_o);
    check("abort_en_pulses", 32'(pulses), 32'd0);
    check("abort_acks", 32'(acks), 32'd0);
    xfer(1'b0, 4'hF, 32'h3800_0010, 32'h0, lat, rd, bwe, ba, bdi, pulses);
    check("abort_next_latency", 32'(lat), 32'd12);
    check("abort_next_rdata", rd, 32'hDEAD_BEEF);

    // Address outside this block held for 30 cycles
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0000;
    pulses = 0; acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      pulses += int'(en0) + int'(en1);
      acks   += int'(wb0.wbs_ack_o) + int'(wb1.wbs_ack_o);
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    check("miss_en_pulses", 32'(pulses), 32'd0);
    check("miss_acks", 32'(acks), 32'd0);

    // Reset in the middle of a read's wait period
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0020; dat = 32'h0;
    acks = 0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ctl",  {29'd0, wb0.wbs_ack_o, en0, |bwe0}, 32'h0);
    check("midrst_data", ba0 | bdi0 | wb0.wbs_dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      acks += int'(wb0.wbs_ack_o) + int'(en0);
    end
    check("midrst_no_ack", 32'(acks), 32'd0);
    xfer(1'b0, 4'hF, 32'h3800_0020, 32'h0, lat, rd, bwe, ba, bdi, pulses);
    check("midrst_next_latency", 32'(lat), 32'd12);
    check("midrst_next_rdata", rd, 32'h11AA_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
